branch_predict_unit: RTL and testbench

//  Next-generation branch unit for the 5-stage RISC-V pipeline: IF-side BHT/BTB prediction plus EX-side resolution.
//  IF looks up 2-bit counters and a direct-mapped BTB by fetch PC. EX computes the real outcome, redirects on mispredict
//  and trains the tables. Replaces the stateless EX-only branch select; PC_Imm/PC_Four outputs keep their meaning.

---
 rtl/branch_pkg.sv | 38 +++
 rtl/btb_bank.sv | 50 +++++
 rtl/branch_predict_unit.sv | 138 +++++++++++++
 tb/tb_branch_predict_unit.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/branch_pkg.sv
// Shared types for the branch predict unit.
//   bht_state_e : 2-bit saturating direction counter (SNT/WNT/WT/ST)
//   btb_entry_t : one direct-mapped BTB line {valid, tag, target}
//   bht_next()  : saturating counter step for a resolved direction
// The BTB entry layout is sized from BP_PC_W/BP_IDX_W. Top-level width
// overrides therefore have to be mirrored here.
package branch_pkg;

  localparam int BP_PC_W   = 9;
  localparam int BP_IDX_W  = 4;
  localparam int BP_CNT_W  = 32;
  localparam int BP_TAG_W  = BP_PC_W - BP_IDX_W - 2;

  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } bht_state_e;

  typedef struct packed {
    logic                valid;
    logic [BP_TAG_W-1:0] tag;
    logic [BP_PC_W-1:0]  target;
  } btb_entry_t;

  function automatic bht_state_e bht_next(input bht_state_e state, input logic taken);
    bht_state_e nxt;
    nxt = state;
    if (taken) begin
      if (state != ST) nxt = bht_state_e'(state + 2'd1);
    end else begin
      if (state != SNT) nxt = bht_state_e'(state - 2'd1);
    end
    return nxt;
  endfunction

endpackage

// File: rtl/btb_bank.sv
// Direct-mapped branch target buffer storage.
// Ports:
//   clk, reset        clock, asynchronous active-low reset (clears valid bits only)
//   rd_idx / rd_entry combinational read port
//   wr_en / wr_idx / wr_entry  write port, committed on the rising clock edge
// Tag and target arrays carry no reset: an entry is never read as a hit
// until its valid bit has been set by a write that also loads them.
module btb_bank
  import branch_pkg::*;
#(
  parameter int IDX_W = BP_IDX_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [IDX_W-1:0] rd_idx,
  output btb_entry_t       rd_entry,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  btb_entry_t       wr_entry
);

  localparam int ENTRIES = 1 << IDX_W;

  logic                valid_q  [ENTRIES];
  logic [BP_TAG_W-1:0] tag_q    [ENTRIES];
  logic [BP_PC_W-1:0]  target_q [ENTRIES];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < ENTRIES; i++) valid_q[i] <= 1'b0;
    end else if (wr_en) begin
      valid_q[wr_idx] <= wr_entry.valid;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      tag_q[wr_idx]    <= wr_entry.tag;
      target_q[wr_idx] <= wr_entry.target;
    end
  end

  always_comb begin
    rd_entry        = '0;
    rd_entry.valid  = valid_q[rd_idx];
    rd_entry.tag    = tag_q[rd_idx];
    rd_entry.target = target_q[rd_idx];
  end

endmodule

// File: rtl/branch_predict_unit.sv
// Branch unit: IF-side prediction (2-bit BHT + direct-mapped BTB) and
// EX-side resolution, redirect and table training.
// Ports:
//   clk, reset                     clock, asynchronous active-low reset
//   if_pc -> if_pred_taken/target  combinational lookup, old entry on same-cycle train
//   ex_valid, ex_stall             qualify redirect (valid) and training (valid & ~stall)
//   Cur_PC, Imm, Branch, Jal, JaltoReg, AluResult, ex_pred_taken, ex_pred_target
//   PC_Imm, PC_Four, BrPC, PcSel   resolution results; BrPC is 0 unless PcSel
//   perf_branches, perf_mispred    saturating event counters
// Build option: define BRANCH_PERF_EN to build the perf counters; without it
// the perf ports are tied to zero.
module branch_predict_unit
  import branch_pkg::*;
#(
  parameter int PC_W  = BP_PC_W,
  parameter int IDX_W = BP_IDX_W,
  parameter int CNT_W = BP_CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [PC_W-1:0]  if_pc,
  output logic             if_pred_taken,
  output logic [31:0]      if_pred_target,
  input  logic             ex_valid,
  input  logic             ex_stall,
  input  logic [PC_W-1:0]  Cur_PC,
  input  logic [31:0]      Imm,
  input  logic             Branch,
  input  logic             Jal,
  input  logic             JaltoReg,
  input  logic [31:0]      AluResult,
  input  logic             ex_pred_taken,
  input  logic [31:0]      ex_pred_target,
  output logic [31:0]      PC_Imm,
  output logic [31:0]      PC_Four,
  output logic [31:0]      BrPC,
  output logic             PcSel,
  output logic [CNT_W-1:0] perf_branches,
  output logic [CNT_W-1:0] perf_mispred
);

  localparam int ENTRIES = 1 << IDX_W;

  bht_state_e bht [ENTRIES];

  // ---------------- IF lookup ----------------
  logic [IDX_W-1:0]      if_idx;
  logic [PC_W-IDX_W-3:0] if_tag;
  btb_entry_t            if_entry;
  logic [1:0]            if_cnt;
  logic                  if_hit;
  logic [1:0]            unused_if_pc;

  assign if_idx       = if_pc[IDX_W+1:2];
  assign if_tag       = if_pc[PC_W-1:IDX_W+2];
  assign unused_if_pc = if_pc[1:0];
  assign if_cnt       = bht[if_idx];
  assign if_hit       = if_entry.valid && (if_entry.tag == if_tag);

  assign if_pred_taken  = if_hit & if_cnt[1];
  assign if_pred_target = if_pred_taken ? {{(32-PC_W){1'b0}}, if_entry.target} : 32'd0;

  // ---------------- EX resolution ----------------
  logic [31:0]           cur_pc_ext;
  logic                  is_ctrl;
  logic                  actual_taken;
  logic [31:0]           actual_target;
  logic                  mispredict;
  logic                  train;
  logic [IDX_W-1:0]      ex_idx;
  btb_entry_t            wr_entry;

  assign cur_pc_ext    = {{(32-PC_W){1'b0}}, Cur_PC};
  assign PC_Imm        = cur_pc_ext + Imm;
  assign PC_Four       = cur_pc_ext + 32'd4;
  assign is_ctrl       = Branch | Jal | JaltoReg;
  assign actual_taken  = Jal | JaltoReg | (Branch & AluResult[0]);
  // JALR target comes from the ALU with bit 0 cleared, never from PC_Imm.
  assign actual_target = JaltoReg ? {AluResult[31:1], 1'b0} : PC_Imm;
  assign mispredict    = (actual_taken != ex_pred_taken) |
                         (actual_taken & (ex_pred_target != actual_target));
  assign PcSel         = ex_valid & mispredict;
  assign BrPC          = PcSel ? (actual_taken ? actual_target : PC_Four) : 32'd0;

  assign train  = ex_valid & ~ex_stall & is_ctrl;
  assign ex_idx = Cur_PC[IDX_W+1:2];

  always_comb begin
    wr_entry        = '0;
    wr_entry.valid  = 1'b1;
    wr_entry.tag    = Cur_PC[PC_W-1:IDX_W+2];
    wr_entry.target = actual_target[PC_W-1:0];
  end

  btb_bank #(
    .IDX_W(IDX_W)
  ) u_btb (
    .clk      (clk),
    .reset    (reset),
    .rd_idx   (if_idx),
    .rd_entry (if_entry),
    .wr_en    (train & actual_taken),
    .wr_idx   (ex_idx),
    .wr_entry (wr_entry)
  );

  // Unconditional jumps always go strongly taken.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < ENTRIES; i++) bht[i] <= WNT;
    end else if (train) begin
      bht[ex_idx] <= (Jal | JaltoReg) ? ST : bht_next(bht[ex_idx], actual_taken);
    end
  end

  // ---------------- performance counters ----------------
`ifdef BRANCH_PERF_EN
  logic [CNT_W-1:0] perf_br_q;
  logic [CNT_W-1:0] perf_mp_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      perf_br_q <= '0;
      perf_mp_q <= '0;
    end else if (train) begin
      if (perf_br_q != '1) perf_br_q <= perf_br_q + 1'b1;
      if (PcSel && (perf_mp_q != '1)) perf_mp_q <= perf_mp_q + 1'b1;
    end
  end

  assign perf_branches = perf_br_q;
  assign perf_mispred  = perf_mp_q;
`else
  assign perf_branches = '0;
  assign perf_mispred  = '0;
`endif

endmodule

// File: tb/tb_branch_predict_unit.sv
module tb_branch_predict_unit;

  logic        clk;
  logic        reset;
  logic [8:0]  if_pc;
  logic        if_pred_taken;
  logic [31:0] if_pred_target;
  logic        ex_valid;
  logic        ex_stall;
  logic [8:0]  Cur_PC;
  logic [31:0] Imm;
  logic        Branch;
  logic        Jal;
  logic        JaltoReg;
  logic [31:0] AluResult;
  logic        ex_pred_taken;
  logic [31:0] ex_pred_target;
  logic [31:0] PC_Imm;
  logic [31:0] PC_Four;
  logic [31:0] BrPC;
  logic        PcSel;
  logic [31:0] perf_branches;
  logic [31:0] perf_mispred;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: plain integers per table slot.
  int          m_cnt [16];
  bit          m_val [16];
  int unsigned m_tag [16];
  int unsigned m_tgt [16];
  int unsigned m_perf_br;
  int unsigned m_perf_mp;

  branch_predict_unit dut (
    .clk            (clk),
    .reset          (reset),
    .if_pc          (if_pc),
    .if_pred_taken  (if_pred_taken),
    .if_pred_target (if_pred_target),
    .ex_valid       (ex_valid),
    .ex_stall       (ex_stall),
    .Cur_PC         (Cur_PC),
    .Imm            (Imm),
    .Branch         (Branch),
    .Jal            (Jal),
    .JaltoReg       (JaltoReg),
    .AluResult      (AluResult),
    .ex_pred_taken  (ex_pred_taken),
    .ex_pred_target (ex_pred_target),
    .PC_Imm         (PC_Imm),
    .PC_Four        (PC_Four),
    .BrPC           (BrPC),
    .PcSel          (PcSel),
    .perf_branches  (perf_branches),
    .perf_mispred   (perf_mispred)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %h expected %h", name, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) begin
      m_cnt[i] = 1;
      m_val[i] = 0;
      m_tag[i] = 0;
      m_tgt[i] = 0;
    end
    m_perf_br = 0;
    m_perf_mp = 0;
  endtask

  task automatic model_lookup(input int unsigned pc, output bit pt, output bit [31:0] ptgt);
    int unsigned idx, tag;
    idx  = (pc / 4) % 16;
    tag  = pc / 64;
    pt   = m_val[idx] && (m_tag[idx] == tag) && (m_cnt[idx] >= 2);
    ptgt = pt ? m_tgt[idx] : 0;
  endtask

  task automatic model_ex(output bit taken, output bit [31:0] tgt, output bit [31:0] pcimm,
                          output bit [31:0] pcfour, output bit sel, output bit [31:0] brpc);
    bit mis;
    pcimm  = 32'(Cur_PC) + Imm;
    pcfour = 32'(Cur_PC) + 32'd4;
    taken  = Jal || JaltoReg || (Branch && AluResult[0]);
    tgt    = JaltoReg ? (AluResult & ~32'd1) : pcimm;
    mis    = (taken != ex_pred_taken) || (taken && (ex_pred_target != tgt));
    sel    = ex_valid && mis;
    brpc   = sel ? (taken ? tgt : pcfour) : 32'd0;
  endtask

  task automatic check_all(input string tag);
    bit pt, taken, sel;
    bit [31:0] ptgt, tgt, pcimm, pcfour, brpc;
    model_lookup(int'(if_pc), pt, ptgt);
    model_ex(taken, tgt, pcimm, pcfour, sel, brpc);
    check({tag, ".pred_taken"},  32'(if_pred_taken), 32'(pt));
    check({tag, ".pred_target"}, if_pred_target, ptgt);
    check({tag, ".PcSel"},       32'(PcSel), 32'(sel));
    check({tag, ".BrPC"},        BrPC, brpc);
    check({tag, ".PC_Imm"},      PC_Imm, pcimm);
    check({tag, ".PC_Four"},     PC_Four, pcfour);
`ifdef BRANCH_PERF_EN
    check({tag, ".perf_br"},     perf_branches, m_perf_br);
    check({tag, ".perf_mp"},     perf_mispred, m_perf_mp);
`else
    check({tag, ".perf_br"},     perf_branches, 32'd0);
    check({tag, ".perf_mp"},     perf_mispred, 32'd0);
`endif
  endtask

  task automatic model_commit();
    bit taken, sel;
    bit [31:0] tgt, pcimm, pcfour, brpc;
    int unsigned idx;
    model_ex(taken, tgt, pcimm, pcfour, sel, brpc);
    if (ex_valid && !ex_stall && (Branch || Jal || JaltoReg)) begin
      idx = (int'(Cur_PC) / 4) % 16;
      if (Jal || JaltoReg) m_cnt[idx] = 3;
      else if (taken)      m_cnt[idx] = (m_cnt[idx] < 3) ? m_cnt[idx] + 1 : 3;
      else                 m_cnt[idx] = (m_cnt[idx] > 0) ? m_cnt[idx] - 1 : 0;
      if (taken) begin
        m_val[idx] = 1;
        m_tag[idx] = int'(Cur_PC) / 64;
        m_tgt[idx] = tgt % 512;
      end
      if (m_perf_br != 32'hFFFF_FFFF) m_perf_br++;
      if (sel && m_perf_mp != 32'hFFFF_FFFF) m_perf_mp++;
    end
  endtask

  // Called right after a falling edge with inputs already driven.
  task automatic cycle(input string tag);
    #1;
    check_all(tag);
    @(posedge clk);
    model_commit();
    @(negedge clk);
  endtask

  task automatic set_ex(input bit v, input bit s, input int unsigned pc, input bit [31:0] imm,
                        input bit br, input bit j, input bit jr, input bit [31:0] alu,
                        input bit pt, input bit [31:0] ptgt);
    ex_valid = v; ex_stall = s; Cur_PC = 9'(pc); Imm = imm;
    Branch = br; Jal = j; JaltoReg = jr; AluResult = alu;
    ex_pred_taken = pt; ex_pred_target = ptgt;
  endtask

  initial begin
    bit pt;
    bit [31:0] ptgt;
    int kind;

    reset = 1'b0;
    if_pc = 9'h040;
    set_ex(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    model_reset();
    #3;
    check("reset.pred_taken",  32'(if_pred_taken), 32'd0);
    check("reset.pred_target", if_pred_target, 32'd0);
    check("reset.PcSel",       32'(PcSel), 32'd0);
    check("reset.perf_br",     perf_branches, 32'd0);
    check("reset.perf_mp",     perf_mispred, 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;

    // Taken branch, predicted not-taken: redirect to PC+Imm, then BTB hit.
    set_ex(1, 0, 'h040, 'h20, 1, 0, 0, 1, 0, 0);
    #1;
    check("t2.PcSel", 32'(PcSel), 32'd1);
    check("t2.BrPC",  BrPC, 32'h60);
    cycle("t2");
    set_ex(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    check("t2.lookup_taken",  32'(if_pred_taken), 32'd1);
    check("t2.lookup_target", if_pred_target, 32'h60);
    cycle("t2b");

    // Same branch not taken while predicted taken: fall-through redirect, WT->WNT.
    set_ex(1, 0, 'h040, 'h20, 1, 0, 0, 0, 1, 'h60);
    #1;
    check("t3.PcSel", 32'(PcSel), 32'd1);
    check("t3.BrPC",  BrPC, 32'h44);
    cycle("t3");
    set_ex(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    check("t3.lookup_taken", 32'(if_pred_taken), 32'd0);
    cycle("t3b");

    // JALR target from the ALU with bit 0 cleared.
    if_pc = 9'h080;
    set_ex(1, 0, 'h080, 'h40, 0, 0, 1, 32'h0000_0105, 0, 0);
    #1;
    check("t4.BrPC", BrPC, 32'h104);
    cycle("t4");
    set_ex(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    check("t4.lookup_taken",  32'(if_pred_taken), 32'd1);
    check("t4.lookup_target", if_pred_target, 32'h104);
    cycle("t4b");

    // Alias: 0x140 shares the index of 0x040 but not the tag.
    if_pc = 9'h040;
    set_ex(1, 0, 'h040, 'h20, 1, 0, 0, 1, 0, 0);
    cycle("t5a");
    set_ex(1, 0, 'h140, 'h20, 1, 0, 0, 1, 0, 0);
    cycle("t5b");
    set_ex(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    check("t5.alias_miss", 32'(if_pred_taken), 32'd0);
    cycle("t5c");
    if_pc = 9'h140;
    #1;
    check("t5.hit_taken",  32'(if_pred_taken), 32'd1);
    check("t5.hit_target", if_pred_target, 32'h160);
    cycle("t5d");

    // Stalled or invalid EX must not train.
    if_pc = 9'h0C4;
    set_ex(1, 1, 'h0C4, 'h10, 1, 0, 0, 1, 0, 0);
    cycle("t6_stall");
    set_ex(0, 0, 'h0C4, 'h10, 1, 0, 0, 1, 0, 0);
    #1;
    check("t6.no_redirect", 32'(PcSel), 32'd0);
    cycle("t6_invalid");
    set_ex(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    check("t6.no_train", 32'(if_pred_taken), 32'd0);
    cycle("t6c");

    // Randomized traffic against the reference model.
    for (int n = 0; n < 400; n++) begin
      kind = $urandom_range(0, 3);
      Cur_PC    = 9'($urandom_range(0, 127) * 4);
      Imm       = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 255) * 4);
      Branch    = (kind == 1);
      Jal       = (kind == 2);
      JaltoReg  = (kind == 3);
      AluResult = $urandom;
      ex_valid  = ($urandom_range(0, 9) != 0);
      ex_stall  = ($urandom_range(0, 6) == 0);
      model_lookup(int'(Cur_PC), pt, ptgt);
      if ($urandom_range(0, 1) == 0) begin
        ex_pred_taken  = pt;
        ex_pred_target = ptgt;
      end else begin
        ex_pred_taken  = 1'($urandom_range(0, 1));
        ex_pred_target = ex_pred_taken ? (($urandom_range(0, 1) == 0) ? PC_Imm : $urandom) : 32'd0;
      end
      if_pc = ($urandom_range(0, 1) == 0) ? Cur_PC : 9'($urandom_range(0, 511));
      cycle("rand");

      // Asynchronous reset mid-stream wipes all learned state.
      if (n == 250) begin
        if_pc = 9'h080;
        set_ex(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        #2;
        reset = 1'b0;
        model_reset();
        #1;
        check("midreset.pred_taken", 32'(if_pred_taken), 32'd0);
        check_all("midreset");
        @(negedge clk);
        reset = 1'b1;
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
